// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the LC-3b pipeline hazard controller: register index, FSM state and the
// bundle of per-stage load/flush controls with the canned control patterns.
package pipeline_hazard_ctrl_pkg;

    typedef logic [2:0] lc3b_reg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DSTALL = 2'd1,
        ISTALL = 2'd2,
        FLUSH  = 2'd3
    } lc3b_hazard_state;

    typedef struct packed {
        logic load_pc;
        logic load_if_id;
        logic load_id_ex;
        logic load_ex_mem;
        logic load_mem_wb;
        logic flush_if_id;
        logic flush_id_ex;
        logic flush_ex_mem;
    } lc3b_pipe_ctrl;

    // Control patterns, bit order matches lc3b_pipe_ctrl
    localparam lc3b_pipe_ctrl CTRL_RUN     = lc3b_pipe_ctrl'(8'b11111_000);
    localparam lc3b_pipe_ctrl CTRL_RESET   = lc3b_pipe_ctrl'(8'b00000_111);
    localparam lc3b_pipe_ctrl CTRL_FREEZE  = lc3b_pipe_ctrl'(8'b00000_000);
    localparam lc3b_pipe_ctrl CTRL_SQUASH  = lc3b_pipe_ctrl'(8'b11111_111);
    localparam lc3b_pipe_ctrl CTRL_BUBBLE  = lc3b_pipe_ctrl'(8'b00111_010);
    localparam lc3b_pipe_ctrl CTRL_DISCARD = lc3b_pipe_ctrl'(8'b00111_110);

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Datapath <-> hazard controller signal bundle. The datapath side is master, the controller slave.
// PIPE_PERF_CNT_EN adds the stall_cycles / flush_count performance counter outputs.
interface pipeline_hazard_ctrl_if
`ifdef PIPE_PERF_CNT_EN
    #(parameter int unsigned PERF_W = 16)
`endif
    ;
    import pipeline_hazard_ctrl_pkg::*;

    lc3b_reg id_src1;
    lc3b_reg id_src2;
    logic    id_use_src1;
    logic    id_use_src2;
    lc3b_reg ex_dest;
    logic    ex_mem_read;
    logic    ex_regwrite;
    logic    imem_req;
    logic    imem_resp;
    logic    dmem_req;
    logic    dmem_resp;
    logic    br_taken;

    logic    load_pc;
    logic    load_if_id;
    logic    load_id_ex;
    logic    load_ex_mem;
    logic    load_mem_wb;
    logic    flush_if_id;
    logic    flush_id_ex;
    logic    flush_ex_mem;
`ifdef PIPE_PERF_CNT_EN
    logic [PERF_W-1:0] stall_cycles;
    logic [PERF_W-1:0] flush_count;
`endif

    modport master (
        output id_src1, id_src2, id_use_src1, id_use_src2, ex_dest, ex_mem_read, ex_regwrite,
               imem_req, imem_resp, dmem_req, dmem_resp, br_taken,
        input  load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
               flush_if_id, flush_id_ex, flush_ex_mem
`ifdef PIPE_PERF_CNT_EN
        , input stall_cycles, flush_count
`endif
    );

    modport slave (
        input  id_src1, id_src2, id_use_src1, id_use_src2, ex_dest, ex_mem_read, ex_regwrite,
               imem_req, imem_resp, dmem_req, dmem_resp, br_taken,
        output load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
               flush_if_id, flush_id_ex, flush_ex_mem
`ifdef PIPE_PERF_CNT_EN
        , output stall_cycles, flush_count
`endif
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Combinational load-use compare between the ID-stage sources and a load sitting in EX.
// R0 is an ordinary register here, so it takes part in the compare.
module load_use_detect
    import pipeline_hazard_ctrl_pkg::*;
(
    input  lc3b_reg id_src1_i,
    input  lc3b_reg id_src2_i,
    input  logic    id_use_src1_i,
    input  logic    id_use_src2_i,
    input  lc3b_reg ex_dest_i,
    input  logic    ex_mem_read_i,
    input  logic    ex_regwrite_i,
    output logic    hazard_o
);

    assign hazard_o = ex_mem_read_i & ex_regwrite_i &
                      ((id_use_src1_i & (id_src1_i == ex_dest_i)) |
                       (id_use_src2_i & (id_src2_i == ex_dest_i)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// LC-3b pipeline sequencer: per-stage load/flush from hazard state and inputs (zero latency).
// PIPE_PERF_CNT_EN adds saturating stall-cycle and branch-squash counters.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
`ifdef PIPE_PERF_CNT_EN
#(
    parameter int unsigned PERF_W = 16
)
`endif
(
    input logic                   clk,
    input logic                   reset_n,
    pipeline_hazard_ctrl_if.slave bus
);

    lc3b_hazard_state state_q, state_d;
    lc3b_pipe_ctrl    ctrl_c;
    logic             hazard;
    logic             d_frozen;
    logic             i_pending;

    load_use_detect u_load_use_detect (
        .id_src1_i     (bus.id_src1),
        .id_src2_i     (bus.id_src2),
        .id_use_src1_i (bus.id_use_src1),
        .id_use_src2_i (bus.id_use_src2),
        .ex_dest_i     (bus.ex_dest),
        .ex_mem_read_i (bus.ex_mem_read),
        .ex_regwrite_i (bus.ex_regwrite),
        .hazard_o      (hazard)
    );

    // Once waiting, only the response matters; the request line is not re-qualified
    always_comb begin
        d_frozen  = (state_q == DSTALL) ? ~bus.dmem_resp : (bus.dmem_req & ~bus.dmem_resp);
        i_pending = (state_q == ISTALL || state_q == FLUSH) ? ~bus.imem_resp
                                                            : (bus.imem_req & ~bus.imem_resp);
    end

    // Priority: reset > dmem freeze > branch squash > stale-fetch discard > imem wait > load-use
    always_comb begin
        ctrl_c  = CTRL_RUN;
        state_d = RUN;
        if (!reset_n) begin
            ctrl_c  = CTRL_RESET;
        end else if (d_frozen) begin
            ctrl_c  = CTRL_FREEZE;
            state_d = DSTALL;
        end else if (bus.br_taken) begin
            ctrl_c  = CTRL_SQUASH;
            state_d = i_pending ? FLUSH : RUN;
        end else if (state_q == FLUSH) begin
            ctrl_c  = CTRL_DISCARD;
            state_d = i_pending ? FLUSH : RUN;
        end else if (i_pending) begin
            ctrl_c  = CTRL_BUBBLE;
            state_d = ISTALL;
        end else if (hazard) begin
            ctrl_c  = CTRL_BUBBLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= RUN;
        else          state_q <= state_d;
    end

    assign bus.load_pc      = ctrl_c.load_pc;
    assign bus.load_if_id   = ctrl_c.load_if_id;
    assign bus.load_id_ex   = ctrl_c.load_id_ex;
    assign bus.load_ex_mem  = ctrl_c.load_ex_mem;
    assign bus.load_mem_wb  = ctrl_c.load_mem_wb;
    assign bus.flush_if_id  = ctrl_c.flush_if_id;
    assign bus.flush_id_ex  = ctrl_c.flush_id_ex;
    assign bus.flush_ex_mem = ctrl_c.flush_ex_mem;

`ifdef PIPE_PERF_CNT_EN
    logic [PERF_W-1:0] stall_cycles_q;
    logic [PERF_W-1:0] flush_count_q;
    logic              squash;

    assign squash = bus.br_taken & ~d_frozen;

    // Saturating counters; reset cycles are not counted
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            if (!ctrl_c.load_pc && stall_cycles_q != '1) stall_cycles_q <= stall_cycles_q + PERF_W'(1);
            if (squash && flush_count_q != '1)           flush_count_q  <= flush_count_q + PERF_W'(1);
        end
    end

    assign bus.stall_cycles = stall_cycles_q;
    assign bus.flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed scenarios plus randomized traffic against a behavioural model of the hazard rules.
// Define PIPE_PERF_CNT_EN to also exercise the performance counters (PERF_W=4).
module tb_pipeline_hazard_ctrl;

    logic clk;
    logic reset_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Model: what the pipeline is currently waiting on
    bit          m_mem_wait;
    bit          m_fetch_wait;
    bit          m_discard;
    int unsigned m_stalls;
    int unsigned m_flushes;
    bit          m_cnt_known;

`ifdef PIPE_PERF_CNT_EN
    localparam int unsigned TB_PERF_W = 4;
    pipeline_hazard_ctrl_if #(.PERF_W(TB_PERF_W)) bus();
    pipeline_hazard_ctrl #(.PERF_W(TB_PERF_W)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
`else
    pipeline_hazard_ctrl_if bus();
    pipeline_hazard_ctrl dut (.clk(clk), .reset_n(reset_n), .bus(bus));
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ctrl_obs();
        return {bus.load_pc, bus.load_if_id, bus.load_id_ex, bus.load_ex_mem, bus.load_mem_wb,
                bus.flush_if_id, bus.flush_id_ex, bus.flush_ex_mem};
    endfunction

    task automatic idle_inputs();
        bus.id_src1 = 3'd0; bus.id_src2 = 3'd0; bus.id_use_src1 = 1'b0; bus.id_use_src2 = 1'b0;
        bus.ex_dest = 3'd0; bus.ex_mem_read = 1'b0; bus.ex_regwrite = 1'b0;
        bus.imem_req = 1'b0; bus.imem_resp = 1'b0;
        bus.dmem_req = 1'b0; bus.dmem_resp = 1'b0; bus.br_taken = 1'b0;
    endtask

    // Inputs are already applied; check mid-low-phase, advance the model across the posedge
    task automatic cycle(input string tag);
        bit          fetch_busy, mem_busy, load_use, squash;
        logic [7:0]  exp;
        int unsigned cap;
        cap = 32'hFFFF;
`ifdef PIPE_PERF_CNT_EN
        cap = (1 << TB_PERF_W) - 1;
`endif
        #1;
        fetch_busy = (m_fetch_wait || m_discard) ? !bus.imem_resp : (bus.imem_req && !bus.imem_resp);
        mem_busy   = m_mem_wait ? !bus.dmem_resp : (bus.dmem_req && !bus.dmem_resp);
        load_use   = bus.ex_mem_read && bus.ex_regwrite &&
                     ((bus.id_use_src1 && bus.id_src1 == bus.ex_dest) ||
                      (bus.id_use_src2 && bus.id_src2 == bus.ex_dest));
        squash = 1'b0;
        if (!reset_n) begin
            exp = 8'b00000_111;
            m_mem_wait = 0; m_fetch_wait = 0; m_discard = 0;
        end else if (mem_busy) begin
            exp = 8'b00000_000;
            m_mem_wait = 1; m_fetch_wait = 0; m_discard = 0;
        end else if (bus.br_taken) begin
            exp = 8'b11111_111;
            squash = 1'b1;
            m_mem_wait = 0; m_fetch_wait = 0; m_discard = fetch_busy;
        end else if (m_discard) begin
            exp = 8'b00111_110;
            m_mem_wait = 0; m_fetch_wait = 0; m_discard = fetch_busy;
        end else if (fetch_busy) begin
            exp = 8'b00111_010;
            m_mem_wait = 0; m_fetch_wait = 1; m_discard = 0;
        end else if (load_use) begin
            exp = 8'b00111_010;
            m_mem_wait = 0; m_fetch_wait = 0; m_discard = 0;
        end else begin
            exp = 8'b11111_000;
            m_mem_wait = 0; m_fetch_wait = 0; m_discard = 0;
        end
        check(tag, ctrl_obs(), exp);
`ifdef PIPE_PERF_CNT_EN
        if (m_cnt_known) begin
            check({tag, "_stallcnt"}, 8'(bus.stall_cycles), 8'(m_stalls));
            check({tag, "_flushcnt"}, 8'(bus.flush_count), 8'(m_flushes));
        end
`endif
        if (!reset_n) begin
            m_stalls = 0; m_flushes = 0; m_cnt_known = 1;
        end else begin
            if (!exp[7] && m_stalls < cap) m_stalls++;
            if (squash && m_flushes < cap) m_flushes++;
        end
        @(negedge clk);
    endtask

    initial begin
        m_mem_wait = 0; m_fetch_wait = 0; m_discard = 0;
        m_stalls = 0; m_flushes = 0; m_cnt_known = 0;
        idle_inputs();

        // Reset held two cycles, then release
        reset_n = 1'b0;
        cycle("reset0");
        cycle("reset1");
        reset_n = 1'b1;
        cycle("run_after_reset");
        check("run_literal", ctrl_obs(), 8'b11111_000);

        // LDR R3 in EX, ADD R1,R3,R2 in ID: one bubble
        bus.ex_dest = 3'd3; bus.ex_mem_read = 1'b1; bus.ex_regwrite = 1'b1;
        bus.id_src1 = 3'd3; bus.id_src2 = 3'd2; bus.id_use_src1 = 1'b1; bus.id_use_src2 = 1'b1;
        cycle("load_use_bubble");
        bus.ex_mem_read = 1'b0; bus.ex_regwrite = 1'b0;
        cycle("load_use_after");

        // R0 dependency through SR2 only
        bus.ex_dest = 3'd0; bus.ex_mem_read = 1'b1; bus.ex_regwrite = 1'b1;
        bus.id_src1 = 3'd5; bus.id_src2 = 3'd0; bus.id_use_src1 = 1'b1; bus.id_use_src2 = 1'b1;
        cycle("load_use_r0");
        bus.id_use_src2 = 1'b0;
        cycle("no_hazard_imm");
        idle_inputs();

        // Data access with the response after four cycles
        bus.dmem_req = 1'b1;
        for (int i = 0; i < 4; i++) cycle("dmem_wait");
        bus.dmem_resp = 1'b1;
        cycle("dmem_resp");
        idle_inputs();
        cycle("dmem_done");

        // Taken branch with a fetch outstanding for three cycles
        bus.br_taken = 1'b1; bus.imem_req = 1'b1;
        cycle("br_squash");
        bus.br_taken = 1'b0;
        cycle("flush_hold0");
        cycle("flush_hold1");
        bus.imem_resp = 1'b1;
        cycle("flush_resp");
        idle_inputs();
        cycle("flush_to_run");

        // Instruction fetch wait
        bus.imem_req = 1'b1;
        cycle("istall0");
        cycle("istall1");
        bus.imem_resp = 1'b1;
        cycle("istall_resp");
        idle_inputs();

        // Branch coinciding with a load-use hazard: squash only
        bus.br_taken = 1'b1;
        bus.ex_dest = 3'd4; bus.ex_mem_read = 1'b1; bus.ex_regwrite = 1'b1;
        bus.id_src1 = 3'd4; bus.id_use_src1 = 1'b1;
        cycle("br_with_hazard");
        idle_inputs();
        cycle("br_hazard_after");

        // Branch raised during a data stall is held off until the response
        bus.dmem_req = 1'b1; bus.br_taken = 1'b1;
        cycle("br_in_dstall0");
        cycle("br_in_dstall1");
        bus.dmem_resp = 1'b1;
        cycle("br_at_dresp");
        idle_inputs();
        cycle("br_dstall_done");

`ifdef PIPE_PERF_CNT_EN
        // Twenty stall cycles saturate a 4-bit counter
        reset_n = 1'b0;
        cycle("perf_reset");
        reset_n = 1'b1;
        bus.dmem_req = 1'b1;
        for (int i = 0; i < 20; i++) cycle("perf_stall");
        idle_inputs();
        cycle("perf_idle");
        check("perf_sat", 8'(bus.stall_cycles), 8'h0F);
`endif

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            reset_n = ($urandom_range(0, 59) != 0);
            bus.dmem_req  = m_mem_wait ? 1'b1 : ($urandom_range(0, 5) == 0);
            bus.dmem_resp = bus.dmem_req ? ($urandom_range(0, 2) == 0) : 1'b0;
            if (!m_mem_wait) bus.br_taken = ($urandom_range(0, 7) == 0);
            bus.imem_req  = (m_fetch_wait || m_discard) ? 1'b1 : ($urandom_range(0, 2) != 0);
            bus.imem_resp = bus.imem_req ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.id_src1     = 3'($urandom_range(0, 3));
            bus.id_src2     = 3'($urandom_range(0, 3));
            bus.id_use_src1 = 1'($urandom_range(0, 1));
            bus.id_use_src2 = 1'($urandom_range(0, 1));
            bus.ex_dest     = 3'($urandom_range(0, 3));
            bus.ex_mem_read = 1'($urandom_range(0, 1));
            bus.ex_regwrite = ($urandom_range(0, 3) != 0);
            cycle("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
